// File: rtl/cmvn_feature_collector_if.sv
// Bus bundle for cmvn_feature_collector: CMVN feature stream plus the random-access read port.
// master: stream producer / reader (drives in_*, rd_en, rd_frame, rd_bin); slave: the collector.
interface cmvn_feature_collector_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int FRAME_W = 6
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [ADDR_W-1:0] in_addr;

    logic               rd_en;
    logic [FRAME_W-1:0] rd_frame;
    logic [ADDR_W-1:0]  rd_bin;
    logic [DATA_W-1:0]  rd_data;
    logic               rd_valid;

    modport master (
        output in_valid, in_data, in_addr,
        output rd_en, rd_frame, rd_bin,
        input  rd_data, rd_valid
    );

    modport slave (
        input  in_valid, in_data, in_addr,
        input  rd_en, rd_frame, rd_bin,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/cmvn_feature_collector.sv
// Collects the CMVN feature stream into a NUM_FRAMES x NUM_BINS buffer with a 1-cycle read port.
// Ports: clk, rst_n (async low), start, clear_err, bus (stream + read), busy, frame_done, frame_count, all_done, addr_err.
module cmvn_feature_collector #(
    parameter int DATA_W     = 32,
    parameter int NUM_BINS   = 20,
    parameter int NUM_FRAMES = 50,
    parameter int ADDR_W     = 5,
    parameter int FRAME_W    = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  clear_err,
    cmvn_feature_collector_if.slave bus,
    output logic                  busy,
    output logic                  frame_done,
    output logic [FRAME_W-1:0]    frame_count,
    output logic                  all_done,
    output logic                  addr_err
);
    localparam int DEPTH = NUM_FRAMES * NUM_BINS;
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] bin_ptr;
    logic [ADDR_W-1:0] last_addr;
    logic              prev_valid;

    logic [DATA_W-1:0] mem [DEPTH];

    logic             beat;
    logic             accept;
    logic             reject;
    logic             last_bin;
    logic             last_frame;
    logic             rd_ok;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    // A held valid with an unchanged address is one beat, not many.
    // A restart in the same cycle takes precedence over any beat.
    always_comb begin
        beat = 1'b0;
        if (state == COLLECT && !start && bus.in_valid) begin
            beat = !prev_valid || (bus.in_addr != last_addr);
        end
        accept     = beat && (bus.in_addr == bin_ptr);
        reject     = beat && (bus.in_addr != bin_ptr);
        last_bin   = (bin_ptr == ADDR_W'(NUM_BINS - 1));
        last_frame = (frame_count == FRAME_W'(NUM_FRAMES - 1));
    end

    always_comb begin
        wr_idx = IDX_W'(frame_count) * IDX_W'(NUM_BINS) + IDX_W'(bin_ptr);
        rd_idx = IDX_W'(bus.rd_frame) * IDX_W'(NUM_BINS) + IDX_W'(bus.rd_bin);
        rd_ok  = (bus.rd_frame < FRAME_W'(NUM_FRAMES)) &&
                 (bus.rd_bin < ADDR_W'(NUM_BINS));
    end

    // Buffer contents survive reset and restarts.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_idx] <= bus.in_data;
        end
    end

    // Read samples the array before this edge's write lands: same-cycle
    // read/write of one location returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
        end else begin
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                bus.rd_data <= rd_ok ? mem[rd_idx] : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            all_done    <= 1'b0;
            addr_err    <= 1'b0;
            bin_ptr     <= '0;
            last_addr   <= '0;
            prev_valid  <= 1'b0;
        end else begin
            prev_valid <= bus.in_valid;
            frame_done <= 1'b0;
            if (beat) begin
                last_addr <= bus.in_addr;
            end
            // A rejected beat wins over a simultaneous clear.
            if (reject) begin
                addr_err <= 1'b1;
            end else if (clear_err) begin
                addr_err <= 1'b0;
            end
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= COLLECT;
                        busy        <= 1'b1;
                        all_done    <= 1'b0;
                        frame_count <= '0;
                        bin_ptr     <= '0;
                    end
                end
                COLLECT: begin
                    if (start) begin
                        frame_count <= '0;
                        bin_ptr     <= '0;
                    end else if (accept) begin
                        if (last_bin) begin
                            bin_ptr     <= '0;
                            frame_count <= frame_count + 1'b1;
                            frame_done  <= 1'b1;
                            if (last_frame) begin
                                state    <= DONE;
                                busy     <= 1'b0;
                                all_done <= 1'b1;
                            end
                        end else begin
                            bin_ptr <= bin_ptr + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/cmvn_feature_collector.md
Name: cmvn_feature_collector

Overview:
Sink for the normalized feature stream leaving the CMVN stage (valid strobe plus 32-bit data plus 5-bit bin address). It checks bin ordering, assembles beats into a NUM_FRAMES x NUM_BINS feature buffer, and reports per-frame and full-window completion. It exposes a registered random-access read port for the downstream keyword-spotting network.

Parameters:
DATA_W, 32, feature word width (signed fixed point, passed through untouched)
NUM_BINS, 20, feature bins per frame
NUM_FRAMES, 50, frames per inference window
ADDR_W, 5, bin address width
FRAME_W, 6, frame index / count width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; arms (or re-arms) collection of a new window
in_valid  input  1  CMVN output valid; may be held high across several cycles
in_data  input  DATA_W  CMVN normalized feature word
in_addr  input  ADDR_W  CMVN bin address of in_data
rd_en  input  1  read request
rd_frame  input  FRAME_W  frame index to read
rd_bin  input  ADDR_W  bin index to read
rd_data  output  DATA_W  read data
rd_valid  output  1  rd_data valid strobe
busy  output  1  high while in COLLECT
frame_done  output  1  one-cycle pulse per completed frame
frame_count  output  FRAME_W  frames completed in current window
all_done  output  1  level; full window captured
addr_err  output  1  sticky out-of-order / out-of-range address flag
clear_err  input  1  clears addr_err

Behaviour:
- Reset (async): state=IDLE; busy, frame_done, all_done, addr_err, rd_valid=0; rd_data=0; frame_count=0; bin_ptr=0; last_addr=0; prev_valid=0. Buffer contents are not reset.
- States: IDLE, COLLECT, DONE.
  - IDLE -> COLLECT on start.
  - COLLECT -> DONE when the beat completing frame NUM_FRAMES-1 is accepted.
  - DONE -> COLLECT on start.
  - start in COLLECT restarts: frame_count=0, bin_ptr=0. The buffer is not cleared.
  - Entering COLLECT clears all_done. It does not clear addr_err.
- Beat qualification (COLLECT only): a beat is a cycle with in_valid=1 AND (prev_valid=0 OR in_addr != last_addr). A level-held valid with an unchanged address is therefore captured exactly once. prev_valid updates every cycle. last_addr updates on every qualified beat.
- Accepted beat (in_addr == bin_ptr):
  - Write buffer[frame_count][bin_ptr] = in_data.
  - bin_ptr++.
  - If bin_ptr was NUM_BINS-1: bin_ptr=0, frame_count++, frame_done=1 in the next cycle for exactly one cycle.
- Rejected beat (in_addr != bin_ptr, including in_addr >= NUM_BINS): no write, counters unchanged, addr_err=1 the next cycle.
- Beats in IDLE/DONE: ignored, no error.
- addr_err priority: clear_err clears the flag. If clear_err and a rejected beat occur in the same cycle, the flag ends set.
- all_done=1 and busy=0 from the cycle after the final accepted beat; frame_done pulses in that same cycle. frame_count holds NUM_FRAMES in DONE.
- Read port, usable in any state, 1-cycle latency:
  - rd_en at edge N gives rd_valid=1 and rd_data at edge N+1.
  - rd_frame >= NUM_FRAMES or rd_bin >= NUM_BINS returns rd_data=0 with rd_valid=1.
  - A read and a write to the same location in the same cycle returns the old data.
  - rd_data holds its value when rd_en=0; rd_valid=0 in that case.
- Data is stored bit-exact, with no arithmetic or sign handling.

Test Plan:
- Frame fill: start; 20 single-cycle beats addr 0..19, data 0x100+addr -> frame_done pulse once, frame_count=1. Then rd_frame=0, rd_bin=7 -> rd_data=0x107, rd_valid one cycle later.
- Held valid: in_valid high 3 cycles at addr 0 data 0xAAAA, then addr 1 -> only one write at bin 0, bin_ptr=2 after addr 1, no addr_err.
- Ordering error: bin_ptr=3, beat addr 5 -> addr_err=1, nothing written. Next beat addr 3 is accepted. clear_err -> addr_err=0.
- Full window: 50x20 ordered beats -> all_done=1, busy=0, frame_count=50. Further beats are ignored; start returns to COLLECT with frame_count=0 and all_done=0.
- Reset mid-op: assert rst_n=0 at frame 10 bin 4 -> all outputs 0 immediately, state IDLE. Beats before start are ignored.
- Bounds read: rd_frame=50, rd_bin=0 or rd_bin=25 -> rd_data=0, rd_valid=1.
